if_stage_ifid: RTL and testbench

- Instruction-fetch stage of the 5-stage pipelined RISC-V core: owns the program counter and the IF/ID pipeline register.
- Directly consumes the load-use hazard unit's outputs: the PC-write enable and the IF/ID stall.
- Also consumes the ID-stage branch flush and the data-cache global stall.
- Produces the PC that addresses instruction memory, and the latched PC/instruction pair consumed by ID.

---
 rtl/if_stage_ifid_pkg.sv | 14 +
 rtl/if_stage_ifid_ifid_reg.sv | 41 ++++
 rtl/if_stage_ifid.sv | 106 ++++++++++
 tb/tb_if_stage_ifid.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/if_stage_ifid_pkg.sv
// Shared core constants and the fetch-state encoding for the IF stage.
package if_stage_ifid_pkg;

    localparam int                   CORE_XLEN     = 32;
    localparam logic [CORE_XLEN-1:0] CORE_RESET_PC = 32'h0000_0000;
    // All-zero word; the decoder treats it as a NOP.
    localparam logic [CORE_XLEN-1:0] NOP_INSTR     = 32'h0000_0000;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_stage_ifid_ifid_reg.sv
// IF/ID pipeline register: hold has priority over flush, flush over load.
module ifid_reg
    import if_stage_ifid_pkg::*;
#(
    parameter int               XLEN         = CORE_XLEN,
    parameter logic [XLEN-1:0]  BUBBLE_INSTR = NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold,
    input  logic            flush,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_instr,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_instr,
    output logic            ifid_valid
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_pc    <= '0;
            ifid_instr <= BUBBLE_INSTR;
            ifid_valid <= 1'b0;
        end else if (hold) begin
            ifid_pc    <= ifid_pc;
            ifid_instr <= ifid_instr;
            ifid_valid <= ifid_valid;
        end else if (flush) begin
            ifid_pc    <= '0;
            ifid_instr <= BUBBLE_INSTR;
            ifid_valid <= 1'b0;
        end else begin
            ifid_pc    <= load_pc;
            ifid_instr <= load_instr;
            ifid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage_ifid.sv
// Instruction-fetch stage: PC register, start/stop FSM and IF/ID register.
// Optional perf counters (stall_cnt_o, flush_cnt_o) under `define IFID_PERF_CNT_EN.
module if_stage_ifid
    import if_stage_ifid_pkg::*;
#(
    parameter int               XLEN         = CORE_XLEN,
    parameter logic [XLEN-1:0]  RESET_PC     = CORE_RESET_PC,
    parameter logic [XLEN-1:0]  BUBBLE_INSTR = NOP_INSTR
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            pc_write_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            mem_stall_i,
    input  logic [XLEN-1:0] imem_instr_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] ifid_pc_o,
    output logic [XLEN-1:0] ifid_instr_o,
    output logic            ifid_valid_o
`ifdef IFID_PERF_CNT_EN
   ,output logic [31:0]     stall_cnt_o,
    output logic [31:0]     flush_cnt_o
`endif
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_d;
    logic            active;
    logic            stall_edge;
    logic            flush_edge;
    logic            ifid_hold;

    // NOTE: every signal driven here gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_o;
        active     = 1'b0;
        stall_edge = 1'b0;
        flush_edge = 1'b0;

        case (state_q)
            IDLE:    if (start_i)  state_d = RUN;
            RUN:     if (!start_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Dropping start_i freezes the stage on the very edge it is sampled.
        active = (state_q == RUN) && start_i;

        if (active && !mem_stall_i) begin
            if (stall_i) begin
                stall_edge = 1'b1;
                if (pc_write_i) pc_d = pc_o + XLEN'(4);
            end else if (flush_i) begin
                flush_edge = 1'b1;
                pc_d       = branch_target_i;
            end else if (pc_write_i) begin
                pc_d = pc_o + XLEN'(4);
            end
        end

        ifid_hold = !active || mem_stall_i || stall_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pc_o    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_o    <= pc_d;
        end
    end

    ifid_reg #(
        .XLEN         (XLEN),
        .BUBBLE_INSTR (BUBBLE_INSTR)
    ) u_ifid_reg (
        .clk        (clk_i),
        .rst        (rst_i),
        .hold       (ifid_hold),
        .flush      (flush_i),
        .load_pc    (pc_o),
        .load_instr (imem_instr_i),
        .ifid_pc    (ifid_pc_o),
        .ifid_instr (ifid_instr_o),
        .ifid_valid (ifid_valid_o)
    );

`ifdef IFID_PERF_CNT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall_edge && (stall_cnt_o != 32'hFFFF_FFFF)) stall_cnt_o <= stall_cnt_o + 32'd1;
            if (flush_edge && (flush_cnt_o != 32'hFFFF_FFFF)) flush_cnt_o <= flush_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage_ifid.sv
// Self-checking bench for if_stage_ifid: directed vector table, async reset
// sequence and a randomized run against a rule-level reference model.
module tb_if_stage_ifid;

    localparam logic [31:0] BUBBLE = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i, pc_write_i, stall_i, flush_i, mem_stall_i;
    logic [31:0] branch_target_i, imem_instr_i;
    logic [31:0] pc_o, ifid_pc_o, ifid_instr_o;
    logic        ifid_valid_o;
    logic [31:0] stall_cnt_o, flush_cnt_o;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    bit          m_run;
    logic [31:0] m_pc, m_ifid_pc, m_ifid_instr;
    logic        m_valid;
    logic [31:0] m_stall_cnt, m_flush_cnt;

    always #5 clk_i = ~clk_i;

    if_stage_ifid dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .pc_write_i      (pc_write_i),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .branch_target_i (branch_target_i),
        .mem_stall_i     (mem_stall_i),
        .imem_instr_i    (imem_instr_i),
        .pc_o            (pc_o),
        .ifid_pc_o       (ifid_pc_o),
        .ifid_instr_o    (ifid_instr_o),
        .ifid_valid_o    (ifid_valid_o)
`ifdef IFID_PERF_CNT_EN
       ,.stall_cnt_o     (stall_cnt_o),
        .flush_cnt_o     (flush_cnt_o)
`endif
    );

`ifndef IFID_PERF_CNT_EN
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

    function automatic logic [31:0] imem_word(input logic [31:0] addr);
        if (addr == 32'h0) return 32'h00A0_0093;
        return (addr * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    assign imem_instr_i = imem_word(pc_o);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ipc,
                                 input logic [31:0] e_instr, input logic e_valid,
                                 input logic [31:0] e_scnt, input logic [31:0] e_fcnt);
        check({tag, ".pc"},    pc_o,         e_pc);
        check({tag, ".ifid_pc"}, ifid_pc_o,  e_ipc);
        check({tag, ".instr"}, ifid_instr_o, e_instr);
        check({tag, ".valid"}, {31'b0, ifid_valid_o}, {31'b0, e_valid});
`ifdef IFID_PERF_CNT_EN
        check({tag, ".stall_cnt"}, stall_cnt_o, e_scnt);
        check({tag, ".flush_cnt"}, flush_cnt_o, e_fcnt);
`endif
    endtask

    task automatic model_reset();
        m_run = 0; m_pc = 32'h0; m_ifid_pc = 32'h0; m_ifid_instr = BUBBLE; m_valid = 0;
        m_stall_cnt = 0; m_flush_cnt = 0;
    endtask

    // One clock edge of the fetch stage, expressed as the priority rules.
    task automatic model_edge();
        if (!m_run) begin
            m_run = start_i;
        end else if (!start_i) begin
            m_run = 0;
        end else if (mem_stall_i) begin
            // frozen
        end else if (stall_i) begin
            if (pc_write_i) m_pc = m_pc + 4;
            if (m_stall_cnt != '1) m_stall_cnt++;
        end else if (flush_i) begin
            m_pc = branch_target_i;
            m_ifid_pc = 0; m_ifid_instr = BUBBLE; m_valid = 0;
            if (m_flush_cnt != '1) m_flush_cnt++;
        end else begin
            m_ifid_pc = m_pc; m_ifid_instr = imem_word(m_pc); m_valid = 1;
            if (pc_write_i) m_pc = m_pc + 4;
        end
    endtask

    task automatic drive(input bit st, input bit pw, input bit sl, input bit fl,
                         input bit ms, input logic [31:0] tgt);
        start_i = st; pc_write_i = pw; stall_i = sl; flush_i = fl; mem_stall_i = ms;
        branch_target_i = tgt;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        drive(0, 0, 0, 0, 0, 32'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit          start, pw, stall, flush, mstall;
        logic [31:0] target;
        logic [31:0] e_pc, e_ipc, e_instr;
        bit          e_valid;
        logic [31:0] e_scnt, e_fcnt;
    } vec_t;

    vec_t vecs[19];

    initial begin
        // Directed table, starting from reset with state IDLE and PC 0.
        vecs[0]  = '{1,1,0,0,0,32'h0,   32'h0,   32'h0,   BUBBLE,              0, 0, 0};
        vecs[1]  = '{1,1,0,0,0,32'h0,   32'h4,   32'h0,   32'h00A0_0093,       1, 0, 0};
        vecs[2]  = '{1,1,0,0,0,32'h0,   32'h8,   32'h4,   imem_word(32'h4),    1, 0, 0};
        vecs[3]  = '{1,0,1,0,0,32'h0,   32'h8,   32'h4,   imem_word(32'h4),    1, 1, 0};
        vecs[4]  = '{1,1,0,0,0,32'h0,   32'hC,   32'h8,   imem_word(32'h8),    1, 1, 0};
        vecs[5]  = '{1,1,0,0,0,32'h0,   32'h10,  32'hC,   imem_word(32'hC),    1, 1, 0};
        vecs[6]  = '{1,1,0,1,0,32'h40,  32'h40,  32'h0,   BUBBLE,              0, 1, 1};
        vecs[7]  = '{1,1,0,0,0,32'h0,   32'h44,  32'h40,  imem_word(32'h40),   1, 1, 1};
        vecs[8]  = '{1,1,1,1,0,32'h100, 32'h48,  32'h40,  imem_word(32'h40),   1, 2, 1};
        vecs[9]  = '{1,1,1,1,1,32'h100, 32'h48,  32'h40,  imem_word(32'h40),   1, 2, 1};
        vecs[10] = '{1,1,0,0,1,32'h0,   32'h48,  32'h40,  imem_word(32'h40),   1, 2, 1};
        vecs[11] = '{1,0,0,0,0,32'h0,   32'h48,  32'h48,  imem_word(32'h48),   1, 2, 1};
        vecs[12] = '{0,1,0,0,0,32'h0,   32'h48,  32'h48,  imem_word(32'h48),   1, 2, 1};
        vecs[13] = '{0,1,0,1,0,32'h80,  32'h48,  32'h48,  imem_word(32'h48),   1, 2, 1};
        vecs[14] = '{1,1,0,0,0,32'h0,   32'h48,  32'h48,  imem_word(32'h48),   1, 2, 1};
        vecs[15] = '{1,1,0,0,0,32'h0,   32'h4C,  32'h48,  imem_word(32'h48),   1, 2, 1};
        vecs[16] = '{1,1,0,1,0,32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, BUBBLE,    0, 2, 2};
        vecs[17] = '{1,1,0,0,0,32'h0,   32'h0,   32'hFFFF_FFFC, imem_word(32'hFFFF_FFFC), 1, 2, 2};
        vecs[18] = '{1,1,1,0,0,32'h0,   32'h4,   32'hFFFF_FFFC, imem_word(32'hFFFF_FFFC), 1, 3, 2};

        do_reset();
        check_outputs("reset", 32'h0, 32'h0, BUBBLE, 0, 0, 0);

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].start, vecs[i].pw, vecs[i].stall, vecs[i].flush, vecs[i].mstall, vecs[i].target);
            @(posedge clk_i); #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_ipc, vecs[i].e_instr,
                          vecs[i].e_valid, vecs[i].e_scnt, vecs[i].e_fcnt);
        end

        // Asynchronous reset asserted mid-stall at PC 0x20.
        do_reset();
        drive(1, 1, 0, 0, 0, 32'h0);
        for (int i = 0; i < 9; i++) begin
            @(posedge clk_i); #1;
        end
        check("pre_areset.pc", pc_o, 32'h20);
        drive(1, 0, 1, 0, 0, 32'h0);
        @(posedge clk_i); #1;
        check("stall_hold.pc", pc_o, 32'h20);
        #2 rst_i = 1'b1;
        #1;
        check_outputs("areset", 32'h0, 32'h0, BUBBLE, 0, 0, 0);
        #1 rst_i = 1'b0;
        model_reset();
        drive(1, 1, 0, 0, 0, 32'h0);
        @(posedge clk_i); #1;
        check_outputs("areset_idle", 32'h0, 32'h0, BUBBLE, 0, 0, 0);

        // Randomized run against the reference model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + ($urandom_range(0, 3) * 4)
                                              : ($urandom & 32'h0000_FFFC);
            drive($urandom_range(0, 19) != 0, $urandom_range(0, 4) != 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0,
                  $urandom_range(0, 9) == 0, tgt);
            model_edge();
            @(posedge clk_i); #1;
            check_outputs($sformatf("rnd%0d", i), m_pc, m_ifid_pc, m_ifid_instr, m_valid,
                          m_stall_cnt, m_flush_cnt);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
